// File: rtl/dec_fgpr_mp.sv
// Floating-point register file: multi-port read/write with nonblocking-load scoreboard.
// Define RV_FGPR_BYPASS_EN to forward same-cycle write data to matching reads.
module dec_fgpr_mp #(
  parameter int NRD  = 6,
  parameter int NWR  = 3,
  parameter int FLEN = 64
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      scan_mode,
  input  logic [NRD-1:0]            rden,
  input  logic [NRD-1:0][4:0]       raddr,
  output logic [NRD-1:0][FLEN-1:0]  rd,
  output logic [NRD-1:0]            rbusy,
  input  logic [NWR-1:0]            wen,
  input  logic [NWR-1:0][4:0]       waddr,
  input  logic [NWR-1:0]            wsp,
  input  logic [NWR-1:0][FLEN-1:0]  wd,
  input  logic                      nb_set,
  input  logic [4:0]                nb_addr,
  input  logic                      nb_flush,
  output logic                      wr_conflict,
  input  logic                      conflict_clr
);

  localparam logic [FLEN-1:0] BOX =
    (FLEN == 64) ? ({FLEN{1'b1}} << 32) : '0;

  logic [31:0][FLEN-1:0]  regs;
  logic [31:0][FLEN-1:0]  wdat;
  logic [NWR-1:0][FLEN-1:0] wfmt;
  logic [31:0]            we;
  logic                   conflict;
  logic [31:0]            pend;
  logic [31:0]            pend_nxt;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wfmt[w] = wsp[w] ? (wd[w] | BOX) : wd[w];
    end
  end

  // Later ports overwrite earlier ones, giving highest-index priority.
  always_comb begin
    we       = '0;
    wdat     = '0;
    conflict = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      if (wen[w]) begin
        if (we[waddr[w]]) conflict = 1'b1;
        we[waddr[w]]   = 1'b1;
        wdat[waddr[w]] = wfmt[w];
      end
    end
  end

  for (genvar r = 0; r < 32; r++) begin : g_reg
    logic [FLEN-1:0] q;
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        q <= '0;
      end else if (we[r] | scan_mode) begin
        q <= we[r] ? wdat[r] : q;
      end
    end
    assign regs[r] = q;
  end

  // A new load issue beats a return to the same register.
  always_comb begin
    pend_nxt = nb_flush ? '0 : pend;
    if (wen[NWR-1]) pend_nxt[waddr[NWR-1]] = 1'b0;
    if (nb_set) pend_nxt[nb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (conflict) wr_conflict <= 1'b1;
      else if (conflict_clr) wr_conflict <= 1'b0;
    end
  end

  logic [FLEN-1:0] v;
  logic            fnb;

  always_comb begin
    rd    = '0;
    rbusy = '0;
    v     = '0;
    fnb   = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      v   = regs[raddr[p]];
      fnb = 1'b0;
`ifdef RV_FGPR_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (wen[w] && waddr[w] == raddr[p]) begin
          v   = wfmt[w];
          fnb = (w == NWR - 1);
        end
      end
`endif
      rd[p]    = (rden[p] & rst_l) ? v : '0;
      rbusy[p] = rden[p] & rst_l & pend[raddr[p]] & ~fnb;
    end
  end

endmodule

// File: tb/tb_dec_fgpr_mp.sv
// Self-checking bench for dec_fgpr_mp: per-cycle model compare plus directed checks.
// Honours RV_FGPR_BYPASS_EN the same way as the design.
module tb_dec_fgpr_mp;
  localparam int NRD  = 6;
  localparam int NWR  = 3;
  localparam int FLEN = 64;

  logic                     clk;
  logic                     rst_l;
  logic                     scan_mode;
  logic [NRD-1:0]           rden;
  logic [NRD-1:0][4:0]      raddr;
  logic [NRD-1:0][FLEN-1:0] rd;
  logic [NRD-1:0]           rbusy;
  logic [NWR-1:0]           wen;
  logic [NWR-1:0][4:0]      waddr;
  logic [NWR-1:0]           wsp;
  logic [NWR-1:0][FLEN-1:0] wd;
  logic                     nb_set;
  logic [4:0]               nb_addr;
  logic                     nb_flush;
  logic                     wr_conflict;
  logic                     conflict_clr;

  int checks = 0;
  int errors = 0;

  dec_fgpr_mp #(.NRD(NRD), .NWR(NWR), .FLEN(FLEN)) dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
    .rden(rden), .raddr(raddr), .rd(rd), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wsp(wsp), .wd(wd),
    .nb_set(nb_set), .nb_addr(nb_addr), .nb_flush(nb_flush),
    .wr_conflict(wr_conflict), .conflict_clr(conflict_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mregs [32];
  logic [31:0] mpend;
  logic        mconf;

  function automatic logic [63:0] box(input logic sp, input logic [63:0] d);
    return sp ? {32'hFFFF_FFFF, d[31:0]} : d;
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] a);
    logic [63:0] v;
    v = mregs[a];
`ifdef RV_FGPR_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wen[w] && waddr[w] == a) v = box(wsp[w], wd[w]);
`endif
    return v;
  endfunction

  function automatic logic fwd_nb(input logic [4:0] a);
`ifdef RV_FGPR_BYPASS_EN
    return wen[NWR-1] && waddr[NWR-1] == a;
`else
    return (a != a);
`endif
  endfunction

  function automatic logic mcollide();
    for (int i = 0; i < NWR; i++)
      for (int j = i + 1; j < NWR; j++)
        if (wen[i] && wen[j] && waddr[i] == waddr[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mpend_next();
    logic [31:0] n;
    n = nb_flush ? 32'h0 : mpend;
    if (wen[NWR-1]) n[waddr[NWR-1]] = 1'b0;
    if (nb_set) n[nb_addr] = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
      mpend <= '0;
      mconf <= 1'b0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wen[w]) mregs[waddr[w]] <= box(wsp[w], wd[w]);
      mpend <= mpend_next();
      if (mcollide()) mconf <= 1'b1;
      else if (conflict_clr) mconf <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      logic [63:0] er;
      logic        eb;
      er = (rden[p] && rst_l) ? mread(raddr[p]) : 64'h0;
      eb = rden[p] && rst_l && mpend[raddr[p]] && !fwd_nb(raddr[p]);
      chk($sformatf("rd%0d", p), rd[p], er);
      chk($sformatf("rbusy%0d", p), {63'h0, rbusy[p]}, {63'h0, eb});
    end
    chk("wr_conflict", {63'h0, wr_conflict}, {63'h0, mconf});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    wen = '0; wsp = '0; nb_set = 0; nb_flush = 0; conflict_clr = 0;
  endtask

  initial begin
    rst_l = 0; scan_mode = 0; rden = '1; raddr = '0;
    waddr = '0; wd = '0; nb_addr = '0;
    idle();
    for (int p = 0; p < NRD; p++) raddr[p] = 5'(p);
    repeat (2) settle();
    chk("rst_rd", rd[0], 64'h0);
    tick();
    rst_l = 1;

    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < NRD; p++) raddr[p] = 5'((i * NRD + p) % 32);
      settle();
      chk("init_rd", rd[NRD-1], 64'h0);
      chk("init_busy", {58'h0, rbusy}, 64'h0);
      tick();
    end

    wen = 3'b001; waddr[0] = 5; wsp[0] = 1;
    wd[0] = 64'h1234_5678_3F80_0000;
    tick(); idle();
    raddr[0] = 5;
    settle();
    chk("f5_box", rd[0], 64'hFFFF_FFFF_3F80_0000);
    tick();

    wen = 3'b101; waddr[0] = 7; waddr[2] = 7;
    wd[0] = 64'hA; wd[2] = 64'hB;
    tick(); idle();
    raddr[0] = 7;
    settle();
    chk("f7_prio", rd[0], 64'hB);
    chk("conf_set", {63'h0, wr_conflict}, 64'h1);
    conflict_clr = 1;
    tick(); idle();
    settle();
    chk("conf_clr", {63'h0, wr_conflict}, 64'h0);

    wen = 3'b011; waddr[0] = 8; waddr[1] = 8;
    wd[0] = 64'h1; wd[1] = 64'h2; conflict_clr = 1;
    tick(); idle();
    raddr[0] = 8;
    settle();
    chk("conf_vs_clr", {63'h0, wr_conflict}, 64'h1);
    chk("f8_prio", rd[0], 64'h2);
    conflict_clr = 1;
    tick(); idle();

    nb_set = 1; nb_addr = 9;
    tick(); idle();
    raddr[1] = 9;
    settle();
    chk("f9_busy", {63'h0, rbusy[1]}, 64'h1);
    wen = 3'b100; waddr[2] = 9; wd[2] = 64'hC;
    tick(); idle();
    settle();
    chk("f9_ret_busy", {63'h0, rbusy[1]}, 64'h0);
    chk("f9_ret_rd", rd[1], 64'hC);

    nb_set = 1; nb_addr = 9;
    wen = 3'b100; waddr[2] = 9; wd[2] = 64'hD;
    tick(); idle();
    settle();
    chk("set_wins", {63'h0, rbusy[1]}, 64'h1);
    wen = 3'b001; waddr[0] = 9; wd[0] = 64'hE;
    tick(); idle();
    settle();
    chk("p0_keeps_pend", {63'h0, rbusy[1]}, 64'h1);
    chk("p0_rd", rd[1], 64'hE);

    nb_set = 1; nb_addr = 3;
    tick();
    nb_addr = 4;
    tick();
    nb_addr = 6; nb_flush = 1;
    tick(); idle();
    raddr[0] = 3; raddr[1] = 4; raddr[2] = 6; raddr[3] = 9;
    settle();
    chk("flush_set", {60'h0, rbusy[3:0]}, 64'h4);
    rden[2] = 0;
    settle();
    chk("rden_off_rd", rd[2], 64'h0);
    chk("rden_off_busy", {63'h0, rbusy[2]}, 64'h0);
    rden = '1;

    wen = 3'b010; waddr[1] = 10; wd[1] = 64'h11;
    tick();
    wd[1] = 64'h55; raddr[0] = 10;
    settle();
`ifdef RV_FGPR_BYPASS_EN
    chk("same_cyc", rd[0], 64'h55);
`else
    chk("same_cyc", rd[0], 64'h11);
`endif
    tick(); idle();
    settle();
    chk("f10_after", rd[0], 64'h55);

    for (int c = 0; c < 60; c++) begin
      rden = NRD'($urandom);
      for (int p = 0; p < NRD; p++) raddr[p] = 5'($urandom_range(0, 7));
      wen = NWR'($urandom);
      wsp = NWR'($urandom);
      for (int w = 0; w < NWR; w++) begin
        waddr[w] = 5'($urandom_range(0, 7));
        wd[w] = {$urandom, $urandom};
      end
      nb_set = 1'($urandom);
      nb_addr = 5'($urandom_range(0, 7));
      nb_flush = ($urandom_range(0, 9) == 0);
      conflict_clr = ($urandom_range(0, 3) == 0);
      scan_mode = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle(); scan_mode = 0; rden = '1;

    wen = 3'b001; waddr[0] = 12; wd[0] = 64'h77;
    nb_set = 1; nb_addr = 12;
    #2 rst_l = 0;
    settle();
    idle();
    tick();
    rst_l = 1;
    raddr[0] = 12;
    settle();
    chk("rst_drop_wr", rd[0], 64'h0);
    chk("rst_drop_nb", {63'h0, rbusy[0]}, 64'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_fgpr_mp.md
DEC_FGPR_MP -- requirements
Module: dec_fgpr_mp

Interface
REQ-001 SHALL have parameter NRD, default 6, number of read ports.
REQ-002 SHALL have parameter NWR, default 3, number of write ports; port NWR-1 is the nonblocking-load return port.
REQ-003 SHALL have parameter FLEN, default 64, register width, legal values 32 or 64.
REQ-004 SHALL have port clk  in  1  the single clock.
REQ-005 SHALL have port rst_l  in  1  asynchronous active-low reset.
REQ-006 SHALL have port scan_mode  in  1  passed to clock-gated flops.
REQ-007 SHALL have port rden  in  NRD  per-port read enable.
REQ-008 SHALL have port raddr  in  NRD x 5  per-port read address.
REQ-009 SHALL have port rd  out  NRD x FLEN  per-port read data.
REQ-010 SHALL have port rbusy  out  NRD  per-port flag: the addressed register has a load pending.
REQ-011 SHALL have port wen  in  NWR  per-port write enable.
REQ-012 SHALL have port waddr  in  NWR x 5  per-port write address.
REQ-013 SHALL have port wsp  in  NWR  per-port single-precision write flag.
REQ-014 SHALL have port wd  in  NWR x FLEN  per-port write data.
REQ-015 SHALL have port nb_set  in  1  nonblocking load issued; mark nb_addr pending.
REQ-016 SHALL have port nb_addr  in  5  destination of the issued nonblocking load.
REQ-017 SHALL have port nb_flush  in  1  cancel all pending loads.
REQ-018 SHALL have port wr_conflict  out  1  sticky flag: multi-port write collision.
REQ-019 SHALL have port conflict_clr  in  1  clears wr_conflict.

Function
REQ-020 SHALL hold 32 registers of FLEN bits; each register's flop is enabled only when that register is written.
REQ-021 SHALL return rd[p] = register[raddr[p]] combinationally when rden[p]=1, and all-zero when rden[p]=0.
REQ-022 SHALL drive rbusy[p] = rden[p] & pending[raddr[p]].
REQ-023 SHALL update a written register on the next rising clk edge, so a write becomes visible in the cycle after wen.
REQ-024 SHALL, when FLEN=64 and wsp[w]=1, store {32'hFFFF_FFFF, wd[w][31:0]} (NaN-boxing); wsp SHALL be ignored when FLEN=32.
REQ-025 SHALL, when two or more write ports target the same register in one cycle, store the data from the highest-indexed port and set wr_conflict on the next edge.
REQ-026 SHALL hold wr_conflict at 1 until conflict_clr=1; a conflict in the same cycle as conflict_clr SHALL leave wr_conflict at 1.
REQ-027 SHALL set pending[nb_addr] on the edge after nb_set=1.
REQ-028 SHALL clear pending[waddr[NWR-1]] on the edge after wen[NWR-1]=1.
REQ-029 SHALL leave the bit pending when nb_set and a port NWR-1 write target the same register in one cycle: the set wins, as a new load reissues the register.
REQ-030 SHALL clear all pending bits on the edge after nb_flush=1; a simultaneous nb_set SHALL still set its bit.
REQ-031 SHALL NOT let writes on ports 0..NWR-2 change pending bits.

Reset
REQ-032 SHALL, while rst_l=0, asynchronously clear all registers to 0, all pending bits to 0 and wr_conflict to 0.
REQ-033 SHALL drive rd=0 and rbusy=0 while reset is asserted, and SHALL discard any write or nb_set in flight when reset asserts.

Configuration
REQ-034 SHALL recognise the macro RV_FGPR_BYPASS_EN.
REQ-035 With RV_FGPR_BYPASS_EN defined, SHALL forward same-cycle write data to a matching read, with data formatted as in REQ-024, the port priority of REQ-025, and rbusy forced to 0 when the forwarding port is NWR-1.
REQ-036 Without RV_FGPR_BYPASS_EN, SHALL return the pre-write register contents on a same-cycle read.

Verification
REQ-037 Reset, then read f0..f31 on all ports -> rd=0, rbusy=0, wr_conflict=0.
REQ-038 Write f5 on port 0 with wsp=1 and wd=64'h1234_5678_3F80_0000 -> next cycle rd of f5 = 64'hFFFF_FFFF_3F80_0000.
REQ-039 Ports 0 and 2 both write f7, with 64'hA and 64'hB -> f7 = 64'hB and wr_conflict=1 next cycle; pulse conflict_clr -> wr_conflict=0.
REQ-040 nb_set with nb_addr=9, then a read of f9 -> rbusy=1; port 2 writes f9=64'hC -> next cycle rbusy=0 and rd=64'hC.
REQ-041 Set pending on f3 and f4, then nb_flush together with nb_set on f6 -> only f6 pending.
REQ-042 Port 1 writes f10=64'h55 while port 0 reads f10 in the same cycle -> rd=64'h55 with RV_FGPR_BYPASS_EN defined, otherwise the old value.
